// File: rtl/i2c_reg_ctrl.sv
// rtl/i2c_reg_ctrl.sv - pointer-addressed register bank behind an I2C slave byte engine
// Define I2C_REG_AUTOINC_EN to advance the pointer after every data byte; otherwise it only moves in PTR.
module i2c_reg_ctrl #(
  parameter int               NREGS   = 16,
  parameter logic [NREGS-1:0] RO_MASK = '0,
  parameter logic [7:0]       RST_VAL = 8'h00
) (
  input  logic               CLCK,
  input  logic               RSTN,
  input  logic               start_evt,
  input  logic               stop_evt,
  input  logic               addr_match,
  input  logic               rw,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_req,
  input  logic               mst_nack,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               usr_we,
  input  logic [7:0]         usr_addr,
  input  logic [7:0]         usr_wdata,
  output logic               wr_evt,
  output logic [7:0]         wr_addr,
  output logic [8*NREGS-1:0] regs_out
);

  typedef enum logic [2:0] {IDLE, ADDR, PTR, WR, RD} state_t;

  state_t             state, state_nxt;
  logic [7:0]         ptr, ptr_nxt, ptr_step;
  logic [8*NREGS-1:0] bank;
  logic               in_range, ro_hit, wr_commit, rd_fire;
  logic [7:0]         rd_byte;

  assign in_range = (int'(ptr) < NREGS);

`ifdef I2C_REG_AUTOINC_EN
  // Out-of-range pointers snap back to 0 rather than counting on to 255.
  assign ptr_step = (int'(ptr) >= NREGS - 1) ? 8'd0 : ptr + 8'd1;
`else
  assign ptr_step = ptr;
`endif

  always_comb begin
    rd_byte = 8'hFF;
    ro_hit  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (ptr == 8'(i)) begin
        rd_byte = bank[8*i +: 8];
        ro_hit  = RO_MASK[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_commit = 1'b0;
    rd_fire   = 1'b0;
    if (stop_evt) begin
      state_nxt = IDLE;
    end else if (start_evt) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR: if (addr_match) state_nxt = rw ? RD : PTR;
        PTR: if (rx_valid) begin
          ptr_nxt   = rx_data;
          state_nxt = WR;
        end
        WR: if (rx_valid) begin
          wr_commit = in_range && !ro_hit;
          ptr_nxt   = ptr_step;
        end
        RD: if (mst_nack) begin
          state_nxt = IDLE;
        end else if (tx_req) begin
          rd_fire = 1'b1;
          ptr_nxt = ptr_step;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLCK or negedge RSTN) begin
    if (!RSTN) begin
      ptr      <= 8'd0;
      bank     <= {NREGS{RST_VAL}};
      tx_data  <= 8'hFF;
      tx_valid <= 1'b0;
      wr_evt   <= 1'b0;
      wr_addr  <= 8'd0;
    end else begin
      ptr      <= ptr_nxt;
      tx_valid <= rd_fire;
      wr_evt   <= wr_commit;
      if (wr_commit) wr_addr <= ptr;
      if (rd_fire)   tx_data <= rd_byte;
      // I2C commit takes priority over a user write to the same register.
      for (int i = 0; i < NREGS; i++) begin
        if (wr_commit && ptr == 8'(i))         bank[8*i +: 8] <= rx_data;
        else if (usr_we && usr_addr == 8'(i))  bank[8*i +: 8] <= usr_wdata;
      end
    end
  end

  assign regs_out = bank;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb/tb_i2c_reg_ctrl.sv - randomized self-checking bench for i2c_reg_ctrl against a transaction-level model
module tb_i2c_reg_ctrl;
  localparam int          NREGS = 16;
  localparam logic [15:0] RO    = 16'h0001;
  localparam logic [7:0]  RSTV  = 8'h3C;
`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic CLCK = 1'b0;
  logic RSTN = 1'b0;
  logic start_evt = 0, stop_evt = 0, addr_match = 0, rw = 0, rx_valid = 0;
  logic tx_req = 0, mst_nack = 0, usr_we = 0;
  logic [7:0] rx_data = 0, usr_addr = 0, usr_wdata = 0;
  logic [7:0] tx_data, wr_addr;
  logic tx_valid, wr_evt;
  logic [8*NREGS-1:0] regs_out;

  i2c_reg_ctrl #(.NREGS(NREGS), .RO_MASK(RO), .RST_VAL(RSTV)) dut (
    .CLCK(CLCK), .RSTN(RSTN), .start_evt(start_evt), .stop_evt(stop_evt),
    .addr_match(addr_match), .rw(rw), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_req(tx_req), .mst_nack(mst_nack), .tx_data(tx_data), .tx_valid(tx_valid),
    .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .wr_evt(wr_evt), .wr_addr(wr_addr), .regs_out(regs_out)
  );

  always #5 CLCK = ~CLCK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mregs [NREGS];
  int mptr = 0;
  logic [7:0] wq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_ptr(input int p);
    return AUTOINC ? ((p >= NREGS - 1) ? 0 : p + 1) : p;
  endfunction

  function automatic logic [7:0] mread(input int p);
    return (p < NREGS) ? mregs[p] : 8'hFF;
  endfunction

  task automatic step();
    @(posedge CLCK);
    #1;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NREGS; i++)
      check_eq($sformatf("%s_reg%0d", tag, i), 32'(regs_out[8*i +: 8]), 32'(mregs[i]));
  endtask

  task automatic ev_start();
    start_evt = 1; step(); start_evt = 0;
  endtask

  task automatic ev_stop();
    stop_evt = 1; step(); stop_evt = 0;
  endtask

  task automatic ev_addr(input logic r);
    addr_match = 1; rw = r; step(); addr_match = 0; rw = 0;
  endtask

  task automatic set_ptr(input int p);
    ev_start();
    ev_addr(1'b0);
    rx_valid = 1; rx_data = 8'(p); step(); rx_valid = 0;
    check_eq("ptr_byte_no_wr_evt", 32'(wr_evt), 0);
    mptr = p;
  endtask

  // Write transaction of the bytes in wq, optionally racing random user writes.
  task automatic i2c_write(input int p, input bit do_stop, input bit race_usr);
    logic [7:0] d, ud, ua;
    bit commit, uw;
    set_ptr(p);
    foreach (wq[k]) begin
      d = wq[k];
      commit = (mptr < NREGS) && !RO[mptr % 16];
      uw = race_usr && ($urandom_range(0, 2) == 0);
      ua = 8'($urandom_range(0, NREGS + 3));
      ud = 8'($urandom);
      rx_valid = 1; rx_data = d;
      usr_we = uw; usr_addr = ua; usr_wdata = ud;
      step();
      rx_valid = 0; usr_we = 0;
      check_eq("wr_evt", 32'(wr_evt), 32'(commit));
      if (commit) check_eq("wr_addr", 32'(wr_addr), 32'(mptr));
      if (uw && ua < NREGS) mregs[ua] = ud;
      if (commit) mregs[mptr] = d;
      mptr = next_ptr(mptr);
      step();
      check_eq("wr_evt_pulse", 32'(wr_evt), 0);
    end
    wq.delete();
    if (do_stop) ev_stop();
    check_bank("wr");
  endtask

  // Read transaction at the current pointer, ended by a NACK and STOP.
  task automatic i2c_read(input int n);
    logic [7:0] e;
    ev_start();
    ev_addr(1'b1);
    e = 8'hFF;
    for (int k = 0; k < n; k++) begin
      e = mread(mptr);
      check_eq("tx_valid_idle", 32'(tx_valid), 0);
      tx_req = 1; step(); tx_req = 0;
      check_eq("tx_valid", 32'(tx_valid), 1);
      check_eq("tx_data", 32'(tx_data), 32'(e));
      step();
      check_eq("tx_valid_pulse", 32'(tx_valid), 0);
      mptr = next_ptr(mptr);
    end
    mst_nack = 1; step(); mst_nack = 0;
    tx_req = 1; step(); tx_req = 0;
    check_eq("tx_valid_after_nack", 32'(tx_valid), 0);
    check_eq("tx_data_held", 32'(tx_data), 32'(e));
    ev_stop();
  endtask

  task automatic usr_write(input logic [7:0] a, input logic [7:0] d);
    usr_we = 1; usr_addr = a; usr_wdata = d; step(); usr_we = 0;
    if (a < NREGS) mregs[a] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] old, x;
    int op;
    for (int i = 0; i < NREGS; i++) mregs[i] = RSTV;
    step(); step();
    check_eq("rst_tx_data", 32'(tx_data), 32'hFF);
    check_eq("rst_tx_valid", 32'(tx_valid), 0);
    check_eq("rst_wr_evt", 32'(wr_evt), 0);
    check_eq("rst_wr_addr", 32'(wr_addr), 0);
    check_bank("rst");
    RSTN = 1;
    step();

    // Basic write then read back through a repeated START
    wq = '{8'hA5, 8'h5A};
    i2c_write(3, 1'b1, 1'b0);
    set_ptr(3);
    i2c_read(3);

    // Wrap at the top of the bank and out-of-range pointer
    wq = '{8'h11, 8'h22};
    i2c_write(NREGS - 1, 1'b1, 1'b0);
    wq = '{8'h33, 8'h44};
    i2c_write(8'h20, 1'b1, 1'b0);
    set_ptr(8'h20);
    i2c_read(2);

    // Read-only register
    wq = '{8'h77};
    i2c_write(0, 1'b1, 1'b0);

    // Same-register collision: I2C wins
    set_ptr(2);
    rx_valid = 1; rx_data = 8'h9C; usr_we = 1; usr_addr = 8'd2; usr_wdata = 8'h63;
    step(); rx_valid = 0; usr_we = 0;
    check_eq("coll_wr_evt", 32'(wr_evt), 1);
    mregs[2] = 8'h9C;
    mptr = next_ptr(mptr);
    // Different-register collision: both land
    rx_valid = 1; rx_data = 8'hD1; usr_we = 1; usr_addr = 8'd9; usr_wdata = 8'hE2;
    step(); rx_valid = 0; usr_we = 0;
    mregs[9] = 8'hE2;
    mregs[mptr] = 8'hD1;
    mptr = next_ptr(mptr);
    ev_stop();
    check_bank("coll");

    // STOP beats a data byte in the same cycle
    set_ptr(7);
    rx_valid = 1; rx_data = 8'hEE; stop_evt = 1;
    step(); rx_valid = 0; stop_evt = 0;
    check_eq("stop_wins_wr_evt", 32'(wr_evt), 0);
    check_bank("stop_wins");

    // Out-of-range user write ignored
    usr_write(8'h40, 8'hAB);
    check_bank("usr_oor");

    // A user write in the tx_req cycle is not seen by that read
    set_ptr(5);
    ev_start();
    ev_addr(1'b1);
    old = mregs[5];
    tx_req = 1; usr_we = 1; usr_addr = 8'd5; usr_wdata = ~old;
    step(); tx_req = 0; usr_we = 0;
    check_eq("rd_sample_valid", 32'(tx_valid), 1);
    check_eq("rd_sample_data", 32'(tx_data), 32'(old));
    mregs[5] = ~old;
    mptr = next_ptr(mptr);
    ev_stop();
    check_bank("rd_sample");

    // Two bytes at pointer 4
    wq = '{8'hC1, 8'hC2};
    i2c_write(4, 1'b1, 1'b0);

    // Randomized mix of transactions
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        usr_write(8'($urandom_range(0, NREGS + 5)), 8'($urandom));
      end else if (op == 1) begin
        for (int k = 0; k < $urandom_range(0, 3); k++) wq.push_back(8'($urandom));
        i2c_write($urandom_range(0, NREGS + 4), 1'b1, 1'b1);
      end else if (op == 2) begin
        set_ptr($urandom_range(0, NREGS + 4));
        i2c_read($urandom_range(1, 3));
      end else begin
        i2c_read($urandom_range(1, 2));
      end
    end
    check_bank("rand");

    // Reset in the middle of a write
    set_ptr(6);
    x = 8'($urandom);
    rx_valid = 1; rx_data = x; step();
    #2 RSTN = 0;
    #1;
    rx_valid = 0;
    for (int i = 0; i < NREGS; i++) mregs[i] = RSTV;
    mptr = 0;
    check_eq("midrst_tx_data", 32'(tx_data), 32'hFF);
    check_eq("midrst_tx_valid", 32'(tx_valid), 0);
    check_eq("midrst_wr_evt", 32'(wr_evt), 0);
    check_eq("midrst_wr_addr", 32'(wr_addr), 0);
    check_bank("midrst");
    step();
    RSTN = 1;
    step();
    rx_valid = 1; rx_data = 8'h55; step(); rx_valid = 0;
    check_eq("post_rst_no_wr_evt", 32'(wr_evt), 0);
    tx_req = 1; step(); tx_req = 0;
    check_eq("post_rst_no_tx_valid", 32'(tx_valid), 0);
    check_bank("post_rst");
    i2c_read(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
